// File: rtl/qlink_pkg.sv
// Shared definitions for the qlink receiver: decoder FSM states and default timing constants.
`timescale 1ns/1ps
package qlink_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    GAP   = 3'd2,
    RX    = 3'd3,
    DONE  = 3'd4
  } qlink_state_e;

  localparam int QLINK_DIV       = 8;
  localparam int QLINK_T_LOW     = 5 * QLINK_DIV;
  localparam int QLINK_T_TIMEOUT = 30000;

endpackage

// File: rtl/qlink_fifo.sv
// Output FIFO for decoded words: head word on data_o, drops and flags overflow when full.
`timescale 1ns/1ps
module qlink_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     ready_i,
  input  logic                     ovf_clr_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q;
  logic              pop, wr_en;

  // valid/ready: a word transfers on every cycle where valid_o && ready_i;
  // data_o holds while valid_o is high and ready_i is low.
  assign pop   = (cnt_q != '0) && ready_i;
  assign wr_en = push_i && ((cnt_q != FULL) || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      // A drop in the same cycle as a clear wins, so the event is never lost.
      if (push_i && !wr_en) ovf_q <= 1'b1;
      else if (ovf_clr_i)   ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign valid_o    = (cnt_q != '0);
  assign level_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/qlink_rx.sv
// Pulse-width quasi-UART receiver: short high pulse = 1, long = 0, MSB first, into a FIFO.
// Define QLINK_RX_PARITY_EN to require a trailing even-parity bit on each frame.
`timescale 1ns/1ps
module qlink_rx import qlink_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int DIV       = QLINK_DIV,
  parameter int T_LOW     = 5 * DIV,
  parameter int T_TIMEOUT = QLINK_T_TIMEOUT,
  parameter int CTR_W     = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rstn,
  input  logic                   gpio,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic                   frame_err,
  output qlink_state_e           state_dbg_o
);

  localparam int IW = $clog2(DATA_W + 2);
  localparam logic [CTR_W-1:0] T_LOW_C = CTR_W'(T_LOW);
  localparam logic [CTR_W-1:0] T_TO_C  = CTR_W'(T_TIMEOUT);
`ifdef QLINK_RX_PARITY_EN
  localparam logic [IW-1:0] PAR_IDX  = IW'(DATA_W);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
`endif

  qlink_state_e      state_q, state_d;
  logic [CTR_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              meta_q, sync_q, prev_q;
  logic              ferr_q, ferr_d;
  logic              push;
  logic              rise, fall, pulse_bit, timeout;

  assign rise      = sync_q & ~prev_q;
  assign fall      = ~sync_q & prev_q;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign pulse_bit = (cnt_q < T_LOW_C);
  assign timeout   = (cnt_q >= T_TO_C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      START: begin
        cnt_d = cnt_inc;
        if (fall) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (rise) begin
          state_d = RX;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end
      end
      RX: begin
        cnt_d = cnt_inc;
        if (fall) begin
          cnt_d = '0;
`ifdef QLINK_RX_PARITY_EN
          // Even parity: the parity pulse must equal the XOR of the data bits.
          if (idx_q == PAR_IDX) begin
            if ((^shift_q) == pulse_bit) begin
              state_d = DONE;
            end else begin
              state_d = IDLE;
              ferr_d  = 1'b1;
            end
          end else begin
            shift_d = DATA_W'({shift_q, pulse_bit});
            idx_d   = idx_q + 1'b1;
            state_d = GAP;
          end
`else
          shift_d = DATA_W'({shift_q, pulse_bit});
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == LAST_IDX) ? DONE : GAP;
`endif
        end else if (timeout) begin
          state_d = IDLE;
          ferr_d  = 1'b1;
        end
      end
      DONE: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= gpio;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
    end
  end

  assign frame_err   = ferr_q;
  assign state_dbg_o = state_q;

  qlink_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rstn),
    .push_i      (push),
    .push_data_i (shift_q),
    .ready_i     (out_ready),
    .ovf_clr_i   (ovf_clr),
    .data_o      (out_data),
    .valid_o     (out_valid),
    .level_o     (level),
    .overflow_o  (overflow)
  );

endmodule
